// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: merges instruction and data AXI4 masters onto one external port.
// Reads are arbitrated one burst at a time; data-master writes pass through one transaction at a time.
module axi_rd_arbiter #(
  parameter logic [3:0] INST_ID = 4'h0,
  parameter logic [3:0] DATA_ID = 4'h1,
  parameter bit         RR_EN   = 1'b1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic [1:0]  i_arburst,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic [1:0]  i_rresp,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic [1:0]  d_arburst,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic [1:0]  d_rresp,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  input  logic [31:0] d_awaddr,
  input  logic [7:0]  d_awlen,
  input  logic [2:0]  d_awsize,
  input  logic [1:0]  d_awburst,
  input  logic        d_awvalid,
  output logic        d_awready,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_wlast,
  input  logic        d_wvalid,
  output logic        d_wready,
  output logic [1:0]  d_bresp,
  output logic        d_bvalid,
  input  logic        d_bready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
  r_state_e    r_state_q, r_state_d;
  w_state_e    w_state_q, w_state_d;
  logic        owner_q, owner_d, ptr_q, ptr_d, gnt_data;
  logic [31:0] ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
  logic [7:0]  ar_len_q, ar_len_d, aw_len_q, aw_len_d;
  logic [2:0]  ar_size_q, ar_size_d, aw_size_q, aw_size_d;
  logic [1:0]  ar_burst_q, ar_burst_d, aw_burst_q, aw_burst_d;
  logic        unused_ids;
  // Routing relies solely on the owner register, so returned IDs are ignored.
  assign unused_ids = ^{rid, bid};
  // gnt_data=1 selects the data master; ptr_q=1 means data wins a tie.
  assign gnt_data = (i_arvalid & d_arvalid) ? (RR_EN ? ptr_q : 1'b1) : d_arvalid;
  always_comb begin
    r_state_d  = r_state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    case (r_state_q)
      R_IDLE: if (i_arvalid | d_arvalid) begin
        r_state_d  = R_ADDR;
        owner_d    = gnt_data;
        ar_addr_d  = gnt_data ? d_araddr  : i_araddr;
        ar_len_d   = gnt_data ? d_arlen   : i_arlen;
        ar_size_d  = gnt_data ? d_arsize  : i_arsize;
        ar_burst_d = gnt_data ? d_arburst : i_arburst;
      end
      R_ADDR: if (arready) r_state_d = R_DATA;
      R_DATA: if (rvalid & rready & rlast) begin
        r_state_d = R_IDLE;
        ptr_d     = ~owner_q;
      end
      default: r_state_d = R_IDLE;
    endcase
  end
  always_comb begin
    w_state_d  = w_state_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    case (w_state_q)
      W_IDLE: if (d_awvalid) begin
        w_state_d  = W_ADDR;
        aw_addr_d  = d_awaddr;
        aw_len_d   = d_awlen;
        aw_size_d  = d_awsize;
        aw_burst_d = d_awburst;
      end
      W_ADDR: if (awready) w_state_d = W_DATA;
      W_DATA: if (wvalid & wready & wlast) w_state_d = W_RESP;
      W_RESP: if (bvalid & bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q  <= R_IDLE;
      w_state_q  <= W_IDLE;
      owner_q    <= 1'b0;
      ptr_q      <= 1'b1;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
    end else begin
      r_state_q  <= r_state_d;
      w_state_q  <= w_state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
    end
  end
  // Idle-state readies are gated by reset so nothing handshakes while held in reset.
  assign i_arready = aresetn & (r_state_q == R_IDLE) & i_arvalid & ~gnt_data;
  assign d_arready = aresetn & (r_state_q == R_IDLE) & gnt_data;
  assign arvalid   = r_state_q == R_ADDR;
  assign arid      = owner_q ? DATA_ID : INST_ID;
  assign araddr    = ar_addr_q;
  assign arlen     = ar_len_q;
  assign arsize    = ar_size_q;
  assign arburst   = ar_burst_q;
  assign arlock    = '0;
  assign arcache   = '0;
  assign arprot    = '0;
  assign rready    = (r_state_q == R_DATA) & (owner_q ? d_rready : i_rready);
  assign i_rvalid  = (r_state_q == R_DATA) & ~owner_q & rvalid;
  assign d_rvalid  = (r_state_q == R_DATA) & owner_q & rvalid;
  assign i_rdata   = rdata;
  assign i_rresp   = rresp;
  assign i_rlast   = rlast;
  assign d_rdata   = rdata;
  assign d_rresp   = rresp;
  assign d_rlast   = rlast;
  assign d_awready = aresetn & (w_state_q == W_IDLE);
  assign awvalid   = w_state_q == W_ADDR;
  assign awid      = DATA_ID;
  assign awaddr    = aw_addr_q;
  assign awlen     = aw_len_q;
  assign awsize    = aw_size_q;
  assign awburst   = aw_burst_q;
  assign awlock    = '0;
  assign awcache   = '0;
  assign awprot    = '0;
  assign wid       = DATA_ID;
  assign wdata     = d_wdata;
  assign wstrb     = d_wstrb;
  assign wlast     = d_wlast;
  assign wvalid    = (w_state_q == W_DATA) & d_wvalid;
  assign d_wready  = (w_state_q == W_DATA) & wready;
  assign bready    = (w_state_q == W_RESP) & d_bready;
  assign d_bvalid  = (w_state_q == W_RESP) & bvalid;
  assign d_bresp   = bresp;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: randomized bench for axi_rd_arbiter against a transaction-level arbitration model.
module tb_axi_rd_arbiter;
  localparam logic [3:0] IID = 4'h0, DID = 4'h1;
  logic aclk = 1'b0, aresetn = 1'b0;
  always #5 aclk = ~aclk;
  logic [31:0] i_araddr, d_araddr, d_awaddr, d_wdata, rdata;
  logic [7:0]  i_arlen, d_arlen, d_awlen;
  logic [2:0]  i_arsize, d_arsize, d_awsize;
  logic [1:0]  i_arburst, d_arburst, d_awburst, rresp, bresp;
  logic [3:0]  d_wstrb, rid, bid;
  logic i_arvalid, d_arvalid, i_rready, d_rready, d_awvalid, d_wvalid, d_wlast, d_bready;
  logic arready, rlast, rvalid, awready, wready, bvalid;
  logic        i_arready, i_rlast, i_rvalid, d_arready, d_rlast, d_rvalid, d_awready, d_wready, d_bvalid;
  logic [31:0] i_rdata, d_rdata, araddr, awaddr, wdata;
  logic [1:0]  i_rresp, d_rresp, d_bresp, arburst, arlock, awburst, awlock;
  logic [3:0]  arid, arcache, awid, awcache, wid, wstrb;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic        arvalid, rready, awvalid, wlast, wvalid, bready;
  logic        f_i_arready, f_i_rlast, f_i_rvalid, f_d_arready, f_d_rlast, f_d_rvalid, f_d_awready, f_d_wready, f_d_bvalid;
  logic [31:0] f_i_rdata, f_d_rdata, f_araddr, f_awaddr, f_wdata;
  logic [1:0]  f_i_rresp, f_d_rresp, f_d_bresp, f_arburst, f_arlock, f_awburst, f_awlock;
  logic [3:0]  f_arid, f_arcache, f_awid, f_awcache, f_wid, f_wstrb;
  logic [7:0]  f_arlen, f_awlen;
  logic [2:0]  f_arsize, f_arprot, f_awsize, f_awprot;
  logic        f_arvalid, f_rready, f_awvalid, f_wlast, f_wvalid, f_bready;
  int checks = 0, errors = 0;
  bit fav_d;
  axi_rd_arbiter #(.INST_ID(IID), .DATA_ID(DID), .RR_EN(1'b1)) u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arburst(i_arburst),
    .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arburst(d_arburst),
    .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awburst(d_awburst),
    .d_awvalid(d_awvalid), .d_awready(d_awready),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast), .d_wvalid(d_wvalid), .d_wready(d_wready),
    .d_bresp(d_bresp), .d_bvalid(d_bvalid), .d_bready(d_bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );
  axi_rd_arbiter #(.INST_ID(IID), .DATA_ID(DID), .RR_EN(1'b0)) u_fix (
    .aclk(aclk), .aresetn(aresetn),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arburst(i_arburst),
    .i_arvalid(i_arvalid), .i_arready(f_i_arready),
    .i_rdata(f_i_rdata), .i_rresp(f_i_rresp), .i_rlast(f_i_rlast), .i_rvalid(f_i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arburst(d_arburst),
    .d_arvalid(d_arvalid), .d_arready(f_d_arready),
    .d_rdata(f_d_rdata), .d_rresp(f_d_rresp), .d_rlast(f_d_rlast), .d_rvalid(f_d_rvalid), .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awburst(d_awburst),
    .d_awvalid(d_awvalid), .d_awready(f_d_awready),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast), .d_wvalid(d_wvalid), .d_wready(f_d_wready),
    .d_bresp(f_d_bresp), .d_bvalid(f_d_bvalid), .d_bready(d_bready),
    .arid(f_arid), .araddr(f_araddr), .arlen(f_arlen), .arsize(f_arsize), .arburst(f_arburst),
    .arlock(f_arlock), .arcache(f_arcache), .arprot(f_arprot), .arvalid(f_arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(f_rready),
    .awid(f_awid), .awaddr(f_awaddr), .awlen(f_awlen), .awsize(f_awsize), .awburst(f_awburst),
    .awlock(f_awlock), .awcache(f_awcache), .awprot(f_awprot), .awvalid(f_awvalid), .awready(awready),
    .wid(f_wid), .wdata(f_wdata), .wstrb(f_wstrb), .wlast(f_wlast), .wvalid(f_wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(f_bready)
  );
  task automatic idle_inputs();
    {i_araddr, i_arlen, i_arsize, i_arburst, i_arvalid, i_rready} = '0;
    {d_araddr, d_arlen, d_arsize, d_arburst, d_arvalid, d_rready} = '0;
    {d_awaddr, d_awlen, d_awsize, d_awburst, d_awvalid} = '0;
    {d_wdata, d_wstrb, d_wlast, d_wvalid, d_bready} = '0;
    {arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid} = '0;
  endtask
  task automatic rand_ar();
    i_araddr = $urandom; i_arlen = 8'($urandom_range(0, 3)); i_arsize = 3'($urandom_range(0, 2)); i_arburst = 2'($urandom);
    d_araddr = $urandom; d_arlen = 8'($urandom_range(0, 3)); d_arsize = 3'($urandom_range(0, 2)); d_arburst = 2'($urandom);
  endtask
  task automatic test_reset();
    idle_inputs();
    aresetn = 1'b0;
    {i_arvalid, d_arvalid, d_awvalid, rvalid, bvalid, i_rready, d_rready, d_bready, d_wvalid} = '1;
    #3;
    checks++;
    if ({i_arready, d_arready, d_awready, arvalid, awvalid, i_rvalid, d_rvalid, d_bvalid, wvalid, rready, bready, d_wready} !== 12'h0) begin
      errors++; $display("FAIL reset_handshakes: got %b want 0", {i_arready, d_arready, d_awready, arvalid, awvalid, i_rvalid, d_rvalid, d_bvalid, wvalid, rready, bready, d_wready});
    end
    checks++;
    if ({arlock, arcache, arprot, awlock, awcache, awprot, araddr, arlen, awaddr, awlen} !== '0) begin
      errors++; $display("FAIL reset_fields: got %h want 0", {arlock, arcache, arprot, awlock, awcache, awprot, araddr, arlen, awaddr, awlen});
    end
    repeat (2) @(posedge aclk);
    #1 idle_inputs();
    aresetn = 1'b1;
    fav_d = 1'b1;
    @(negedge aclk);
    checks++;
    if ({d_awready, arvalid, i_arready, d_arready} !== 4'b1000) begin
      errors++; $display("FAIL post_reset_idle: got %b want 1000", {d_awready, arvalid, i_arready, d_arready});
    end
    @(posedge aclk); #1;
  endtask
  // One read burst: the loser keeps requesting throughout, and is dropped at the end.
  task automatic rd_txn(input bit iv, input bit dv, input bit bp);
    bit w;
    logic [31:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b;
    int got, n;
    logic xr;
    i_arvalid = iv; d_arvalid = dv;
    w = (iv && dv) ? fav_d : dv;
    a = w ? d_araddr : i_araddr; l = w ? d_arlen : i_arlen;
    s = w ? d_arsize : i_arsize; b = w ? d_arburst : i_arburst;
    @(negedge aclk);
    checks++;
    if ({i_arready, d_arready} !== {~w, w}) begin
      errors++; $display("FAIL ar_grant: got i/d=%b want %b", {i_arready, d_arready}, {~w, w});
    end
    @(posedge aclk); #1;
    if (w) d_arvalid = 1'b0; else i_arvalid = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(negedge aclk);
      checks++;
      if ({arvalid, arid, araddr, arlen, i_arready, d_arready} !== {1'b1, w ? DID : IID, a, l, 2'b00}) begin
        errors++; $display("FAIL ar_hold: got %h want %h", {arvalid, arid, araddr, arlen, i_arready, d_arready}, {1'b1, w ? DID : IID, a, l, 2'b00});
      end
      @(posedge aclk); #1;
    end
    arready = 1'b1;
    @(negedge aclk);
    checks++;
    if ({arvalid, arid, araddr, arlen, arsize, arburst} !== {1'b1, w ? DID : IID, a, l, s, b}) begin
      errors++; $display("FAIL ar_issue: got %h want %h", {arvalid, arid, araddr, arlen, arsize, arburst}, {1'b1, w ? DID : IID, a, l, s, b});
    end
    @(posedge aclk); #1 arready = 1'b0;
    got = 0; n = 0;
    while (got <= int'(l) && n < 200) begin
      n++;
      rvalid = $urandom_range(0, 3) != 0; rdata = $urandom; rresp = 2'($urandom); rid = 4'($urandom);
      rlast = got == int'(l);
      i_rready = bp ? 1'($urandom) : 1'b1; d_rready = bp ? 1'($urandom) : 1'b1;
      xr = w ? d_rready : i_rready;
      @(negedge aclk);
      checks++;
      if ({i_rvalid, d_rvalid, rready} !== {rvalid & ~w, rvalid & w, xr} ||
          (w ? {d_rdata, d_rresp, d_rlast} : {i_rdata, i_rresp, i_rlast}) !== {rdata, rresp, rlast}) begin
        errors++; $display("FAIL r_route beat %0d: got iv/dv/rr=%b data=%h want %b %h", got, {i_rvalid, d_rvalid, rready},
                           w ? {d_rdata, d_rresp, d_rlast} : {i_rdata, i_rresp, i_rlast}, {rvalid & ~w, rvalid & w, xr}, {rdata, rresp, rlast});
      end
      if (rvalid && xr) got++;
      @(posedge aclk); #1;
    end
    {rvalid, rlast, i_arvalid, d_arvalid} = '0;
    checks++;
    if (got != int'(l) + 1) begin
      errors++; $display("FAIL r_beats: got %0d want %0d", got, int'(l) + 1);
    end
    fav_d = !w;
  endtask
  // One write: a second AW request is held pending and must not be taken until B completes.
  task automatic wr_txn(input logic [31:0] a, input logic [7:0] l);
    int got, n;
    bit done;
    d_awaddr = a; d_awlen = l; d_awsize = 3'd2; d_awburst = 2'd1; d_awvalid = 1'b1;
    @(negedge aclk);
    checks++;
    if (d_awready !== 1'b1) begin
      errors++; $display("FAIL aw_accept: got %b want 1", d_awready);
    end
    @(posedge aclk); #1 d_awaddr = ~a;
    repeat ($urandom_range(0, 2)) begin
      @(negedge aclk);
      checks++;
      if ({awvalid, awid, awaddr, awlen, d_awready} !== {1'b1, DID, a, l, 1'b0}) begin
        errors++; $display("FAIL aw_hold: got %h want %h", {awvalid, awid, awaddr, awlen, d_awready}, {1'b1, DID, a, l, 1'b0});
      end
      @(posedge aclk); #1;
    end
    awready = 1'b1;
    @(negedge aclk);
    checks++;
    if ({awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot} !== {1'b1, DID, a, l, 3'd2, 2'd1, 9'd0}) begin
      errors++; $display("FAIL aw_issue: got %h want %h", {awvalid, awid, awaddr, awlen, awsize, awburst}, {1'b1, DID, a, l, 3'd2, 2'd1});
    end
    @(posedge aclk); #1 awready = 1'b0;
    got = 0; n = 0;
    while (got <= int'(l) && n < 200) begin
      n++;
      d_wvalid = $urandom_range(0, 3) != 0; d_wdata = $urandom; d_wstrb = 4'hF; d_wlast = got == int'(l);
      wready = $urandom_range(0, 3) != 0;
      @(negedge aclk);
      checks++;
      if ({wvalid, d_wready, wid, wdata, wstrb, wlast, awvalid, d_awready} !== {d_wvalid, wready, DID, d_wdata, d_wstrb, d_wlast, 2'b00}) begin
        errors++; $display("FAIL w_pass beat %0d: got %h want %h", got, {wvalid, d_wready, wid, wdata, wstrb, wlast, awvalid, d_awready},
                           {d_wvalid, wready, DID, d_wdata, d_wstrb, d_wlast, 2'b00});
      end
      if (d_wvalid && wready) got++;
      @(posedge aclk); #1;
    end
    {d_wvalid, d_wlast} = '0;
    checks++;
    if (got != int'(l) + 1) begin
      errors++; $display("FAIL w_beats: got %0d want %0d", got, int'(l) + 1);
    end
    done = 1'b0; n = 0;
    while (!done && n < 200) begin
      n++;
      bvalid = 1'($urandom); bresp = 2'($urandom); d_bready = 1'($urandom);
      @(negedge aclk);
      checks++;
      if ({d_bvalid, bready, d_bresp, d_awready, wvalid} !== {bvalid, d_bready, bresp, 2'b00}) begin
        errors++; $display("FAIL b_pass: got %b want %b", {d_bvalid, bready, d_bresp, d_awready, wvalid}, {bvalid, d_bready, bresp, 2'b00});
      end
      done = bvalid && d_bready;
      @(posedge aclk); #1;
    end
    {bvalid, d_bready, d_awvalid} = '0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL b_timeout: got no handshake want one");
    end
  endtask
  task automatic test_single_inst();
    test_reset();
    i_araddr = 32'h1C00_0000; i_arlen = 8'd3; i_arsize = 3'd2; i_arburst = 2'd1;
    rd_txn(1'b1, 1'b0, 1'b0);
  endtask
  task automatic test_round_robin();
    test_reset();
    for (int k = 0; k < 4; k++) begin
      rand_ar();
      rd_txn(1'b1, 1'b1, 1'b0);
    end
  endtask
  task automatic test_fixed_priority();
    test_reset();
    i_arvalid = 1'b1; d_arvalid = 1'b1; i_arlen = 8'd0; d_arlen = 8'd0; i_rready = 1'b1; d_rready = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      if (k == 3) d_arvalid = 1'b0;
      @(negedge aclk);
      checks++;
      if ({f_i_arready, f_d_arready} !== ((k == 3) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL fixed_grant %0d: got %b want %b", k, {f_i_arready, f_d_arready}, (k == 3) ? 2'b10 : 2'b01);
      end
      @(posedge aclk); #1 arready = 1'b1;
      if (k == 3) i_arvalid = 1'b0;
      @(negedge aclk);
      checks++;
      if ({f_arvalid, f_arid, f_i_arready, f_d_arready} !== {1'b1, (k == 3) ? IID : DID, 2'b00}) begin
        errors++; $display("FAIL fixed_arid %0d: got %h want %h", k, {f_arvalid, f_arid, f_i_arready, f_d_arready}, {1'b1, (k == 3) ? IID : DID, 2'b00});
      end
      @(posedge aclk); #1 arready = 1'b0; rvalid = 1'b1; rlast = 1'b1;
      @(negedge aclk);
      checks++;
      if ({f_i_rvalid, f_d_rvalid, f_rready} !== ((k == 3) ? 3'b101 : 3'b011)) begin
        errors++; $display("FAIL fixed_route %0d: got %b want %b", k, {f_i_rvalid, f_d_rvalid, f_rready}, (k == 3) ? 3'b101 : 3'b011);
      end
      @(posedge aclk); #1 rvalid = 1'b0; rlast = 1'b0;
    end
    idle_inputs();
  endtask
  task automatic test_write();
    test_reset();
    wr_txn(32'h1FAF_0000, 8'd1);
  endtask
  task automatic test_concurrent();
    test_reset();
    rand_ar();
    i_arlen = 8'd3;
    fork
      rd_txn(1'b1, 1'b0, 1'b1);
      wr_txn($urandom, 8'd2);
    join
  endtask
  task automatic test_random();
    int m;
    test_reset();
    for (int k = 0; k < 25; k++) begin
      m = $urandom_range(1, 3);
      rand_ar();
      if ($urandom_range(0, 1) == 1)
        fork
          rd_txn(m[0], m[1], 1'b1);
          wr_txn($urandom, 8'($urandom_range(0, 3)));
        join
      else
        rd_txn(m[0], m[1], 1'b1);
    end
  endtask
  task automatic test_reset_mid();
    test_reset();
    i_araddr = 32'h1C00_0040; i_arlen = 8'd3; i_arvalid = 1'b1;
    @(posedge aclk); #1 i_arvalid = 1'b0; arready = 1'b1;
    @(posedge aclk); #1 arready = 1'b0; rvalid = 1'b1; i_rready = 1'b1;
    @(negedge aclk);
    checks++;
    if ({i_rvalid, rready} !== 2'b11) begin
      errors++; $display("FAIL mid_burst_active: got %b want 11", {i_rvalid, rready});
    end
    #1 aresetn = 1'b0; i_arvalid = 1'b1; d_awvalid = 1'b1;
    #1;
    checks++;
    if ({i_rvalid, d_rvalid, rready, arvalid, i_arready, d_arready, d_awready, awvalid} !== 8'h0) begin
      errors++; $display("FAIL mid_burst_reset: got %b want 0", {i_rvalid, d_rvalid, rready, arvalid, i_arready, d_arready, d_awready, awvalid});
    end
    @(posedge aclk); #1 idle_inputs();
    aresetn = 1'b1; fav_d = 1'b1;
    rand_ar();
    rd_txn(1'b1, 1'b1, 1'b0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
  initial begin
    idle_inputs();
    test_reset();
    test_single_inst();
    test_round_robin();
    test_fixed_priority();
    test_write();
    test_concurrent();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
